mouse_click_decoder: RTL and testbench

- Parametrised successor to the board/start-button mouse decoder.
- Maps the mouse position to one of four regions: none, player board, enemy board, button. Geometry comes from parameters.
- Publishes registered hover coordinates every cycle.
- Emits exactly one click event per completed press-and-release inside the same cell. The event uses a valid/ready handshake.
- Sits between the mouse position/button synchroniser and the game control FSM.

---
 rtl/mouse_click_decoder.sv | 277 +++++++++++++++++++++++++++
 tb/tb_mouse_click_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_click_decoder.sv
// -----------------------------------------------------------------------------
// mouse_click_decoder
//
// Purpose:
//   Maps the synchronised mouse position onto one of four screen regions
//   (none, player board, enemy board, button) and publishes the registered
//   hover region and cell every cycle. It emits exactly one click event for
//   each press-and-release that starts and ends in the same cell. The event
//   is offered to the game control FSM through a valid/ready handshake.
//
// Optional feature:
//   Define MOUSE_CLICK_DEBOUNCE_EN to pass `left` through a debounce filter.
//   The filtered level follows the raw level only after the two have differed
//   for DEBOUNCE_CYC consecutive cycles. With the macro undefined, `left` is
//   used directly.
//
// Ports:
//   clk          in   1   clock
//   rst          in   1   synchronous active-high reset
//   x_pos        in  12   mouse x in pixels
//   y_pos        in  12   mouse y in pixels
//   left         in   1   left button level (already synchronised)
//   enable       in   1   0 = no new press is accepted
//   hover_region out  2   0 NONE, 1 PLAYER, 2 ENEMY, 3 BUTTON (1 cycle latency)
//   hover_cor    out  8   {col,row} under cursor; 8'hFF outside the boards
//   evt_valid    out  1   click event pending
//   evt_region   out  2   region of the pending event
//   evt_cor      out  8   cell of the pending event; 8'hFF for BUTTON
//   evt_ready    in   1   consumer accepts the event
// -----------------------------------------------------------------------------
module mouse_click_decoder #(
  parameter int PLAYER_XPOS  = 64,
  parameter int ENEMY_XPOS   = 448,
  parameter int GRID_YPOS    = 128,
  parameter int CELL_SHIFT   = 5,
  parameter int GRID_CELLS   = 10,
  parameter int BTN_XPOS     = 320,
  parameter int BTN_YPOS     = 500,
  parameter int BTN_W        = 160,
  parameter int BTN_H        = 48,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] x_pos,
  input  logic [11:0] y_pos,
  input  logic        left,
  input  logic        enable,
  output logic [1:0]  hover_region,
  output logic [7:0]  hover_cor,
  output logic        evt_valid,
  output logic [1:0]  evt_region,
  output logic [7:0]  evt_cor,
  input  logic        evt_ready
);

  // Region codes
  localparam logic [1:0] REG_NONE   = 2'd0;
  localparam logic [1:0] REG_PLAYER = 2'd1;
  localparam logic [1:0] REG_ENEMY  = 2'd2;
  localparam logic [1:0] REG_BUTTON = 2'd3;

  // FSM states
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PRESSED  = 2'd1;
  localparam logic [1:0] S_WAIT_REL = 2'd2;
  localparam logic [1:0] S_EMIT     = 2'd3;

  localparam int GRID_EXT = GRID_CELLS << CELL_SHIFT;

  // Bounds are compared at 13 bits so base+extent cannot wrap around.
  localparam logic [12:0] PX_LO = 13'(PLAYER_XPOS);
  localparam logic [12:0] PX_HI = 13'(PLAYER_XPOS + GRID_EXT);
  localparam logic [12:0] EX_LO = 13'(ENEMY_XPOS);
  localparam logic [12:0] EX_HI = 13'(ENEMY_XPOS + GRID_EXT);
  localparam logic [12:0] GY_LO = 13'(GRID_YPOS);
  localparam logic [12:0] GY_HI = 13'(GRID_YPOS + GRID_EXT);
  localparam logic [12:0] BX_LO = 13'(BTN_XPOS);
  localparam logic [12:0] BX_HI = 13'(BTN_XPOS + BTN_W);
  localparam logic [12:0] BY_LO = 13'(BTN_YPOS);
  localparam logic [12:0] BY_HI = 13'(BTN_YPOS + BTN_H);

  localparam logic [11:0] PX_BASE = 12'(PLAYER_XPOS);
  localparam logic [11:0] EX_BASE = 12'(ENEMY_XPOS);
  localparam logic [11:0] GY_BASE = 12'(GRID_YPOS);

  // Elaboration-time guard on the configuration.
  if (GRID_CELLS < 1 || GRID_CELLS > 15 || DEBOUNCE_CYC < 1) begin : g_param_err
    $error("mouse_click_decoder: GRID_CELLS must be 1..15 and DEBOUNCE_CYC >= 1");
  end

  // ---------------------------------------------------------------------------
  // Combinational region / cell decode
  // ---------------------------------------------------------------------------
  logic [12:0] w_x13;
  logic [12:0] w_y13;
  logic        w_in_grid_y;
  logic        w_in_player;
  logic        w_in_enemy;
  logic        w_in_button;
  logic [11:0] w_px_off;
  logic [11:0] w_ex_off;
  logic [11:0] w_gy_off;
  logic [3:0]  w_pcol;
  logic [3:0]  w_ecol;
  logic [3:0]  w_row;
  logic [1:0]  w_region_next;
  logic [7:0]  w_cor_next;

  assign w_x13 = {1'b0, x_pos};
  assign w_y13 = {1'b0, y_pos};

  assign w_in_grid_y = (w_y13 >= GY_LO) && (w_y13 < GY_HI);
  assign w_in_player = (w_x13 >= PX_LO) && (w_x13 < PX_HI) && w_in_grid_y;
  assign w_in_enemy  = (w_x13 >= EX_LO) && (w_x13 < EX_HI) && w_in_grid_y;
  assign w_in_button = (w_x13 >= BX_LO) && (w_x13 < BX_HI) &&
                       (w_y13 >= BY_LO) && (w_y13 < BY_HI);

  // Offsets may wrap when out of range; they are only consumed when the
  // matching in-range flag is set.
  assign w_px_off = x_pos - PX_BASE;
  assign w_ex_off = x_pos - EX_BASE;
  assign w_gy_off = y_pos - GY_BASE;
  assign w_pcol   = 4'(w_px_off >> CELL_SHIFT);
  assign w_ecol   = 4'(w_ex_off >> CELL_SHIFT);
  assign w_row    = 4'(w_gy_off >> CELL_SHIFT);

  // Overlap priority: button, then player board, then enemy board.
  always_comb begin
    w_region_next = REG_NONE;
    w_cor_next    = 8'hFF;
    if (w_in_button) begin
      w_region_next = REG_BUTTON;
    end else if (w_in_player) begin
      w_region_next = REG_PLAYER;
      w_cor_next    = {w_pcol, w_row};
    end else if (w_in_enemy) begin
      w_region_next = REG_ENEMY;
      w_cor_next    = {w_ecol, w_row};
    end
  end

  // ---------------------------------------------------------------------------
  // Left button source (optionally debounced)
  // ---------------------------------------------------------------------------
  logic w_left_src;

`ifdef MOUSE_CLICK_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic [DB_W-1:0] r_db_cnt;
  logic            r_left_filt;

  // Counts consecutive cycles where the raw level disagrees with the filtered
  // one; any agreeing cycle restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_cnt    <= '0;
      r_left_filt <= 1'b1;
    end else if (left == r_left_filt) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_left_filt <= left;
      r_db_cnt    <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  assign w_left_src = r_left_filt;
`else
  assign w_left_src = left;
`endif

  // ---------------------------------------------------------------------------
  // Registered hover, press tracking and click FSM
  // ---------------------------------------------------------------------------
  logic [1:0] r_hover_region;
  logic [7:0] r_hover_cor;
  logic       r_left_q;
  logic       r_left_prev;
  logic [1:0] r_state;
  logic [1:0] r_press_region;
  logic [7:0] r_press_cor;
  logic       r_evt_valid;
  logic [1:0] r_evt_region;
  logic [7:0] r_evt_cor;

  logic w_press;
  logic w_match;

  // Rising edge of the registered level. Both flops reset to 1 so that a
  // button held through reset release is not seen as a press.
  assign w_press = r_left_q & ~r_left_prev;
  assign w_match = (r_hover_region == r_press_region) &&
                   (r_hover_cor == r_press_cor);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hover_region <= REG_NONE;
      r_hover_cor    <= 8'hFF;
      r_left_q       <= 1'b1;
      r_left_prev    <= 1'b1;
      r_state        <= S_IDLE;
      r_press_region <= REG_NONE;
      r_press_cor    <= 8'hFF;
      r_evt_valid    <= 1'b0;
      r_evt_region   <= REG_NONE;
      r_evt_cor      <= 8'hFF;
    end else begin
      r_hover_region <= w_region_next;
      r_hover_cor    <= w_cor_next;
      r_left_q       <= w_left_src;
      r_left_prev    <= r_left_q;

      case (r_state)
        S_IDLE: begin
          if (w_press) begin
            if (enable && (r_hover_region != REG_NONE)) begin
              r_press_region <= r_hover_region;
              r_press_cor    <= r_hover_cor;
              r_state        <= S_PRESSED;
            end else begin
              // Presses that cannot produce a click still need a release.
              r_state <= S_WAIT_REL;
            end
          end
        end

        S_PRESSED: begin
          // enable is deliberately ignored here: it only gates new presses.
          if (r_left_q) begin
            if (!w_match) begin
              r_state <= S_WAIT_REL;
            end
          end else if (w_match) begin
            r_evt_valid  <= 1'b1;
            r_evt_region <= r_press_region;
            r_evt_cor    <= r_press_cor;
            r_state      <= S_EMIT;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_WAIT_REL: begin
          if (!r_left_q) begin
            r_state <= S_IDLE;
          end
        end

        S_EMIT: begin
          // Button activity here is ignored; the edge detector keeps running
          // so a button still held on exit needs a fresh release and press.
          if (r_evt_valid && evt_ready) begin
            r_evt_valid  <= 1'b0;
            r_evt_region <= REG_NONE;
            r_evt_cor    <= 8'hFF;
            r_state      <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign hover_region = r_hover_region;
  assign hover_cor    = r_hover_cor;
  assign evt_valid    = r_evt_valid;
  assign evt_region   = r_evt_region;
  assign evt_cor      = r_evt_cor;

endmodule

// File: tb/tb_mouse_click_decoder.sv
// -----------------------------------------------------------------------------
// tb_mouse_click_decoder
//
// Purpose:
//   Directed self-checking bench for mouse_click_decoder with default
//   parameters. Expected hover cells, regions and event timing are computed
//   by hand from the default board/button geometry.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_mouse_click_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] x_pos = '0;
  logic [11:0] y_pos = '0;
  logic        left = 1'b0;
  logic        enable = 1'b1;
  logic        evt_ready = 1'b1;
  logic [1:0]  hover_region;
  logic [7:0]  hover_cor;
  logic        evt_valid;
  logic [1:0]  evt_region;
  logic [7:0]  evt_cor;

  int n_vec = 0;
  int n_bad = 0;

  mouse_click_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .left         (left),
    .enable       (enable),
    .hover_region (hover_region),
    .hover_cor    (hover_cor),
    .evt_valid    (evt_valid),
    .evt_region   (evt_region),
    .evt_cor      (evt_cor),
    .evt_ready    (evt_ready)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got,
                           input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance n clock edges and sample 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hover_chk(input string tag, input logic [11:0] x,
                           input logic [11:0] y, input logic [1:0] h_reg,
                           input logic [7:0] h_cor);
    @(negedge clk);
    x_pos = x;
    y_pos = y;
    tick(1);
    check_val({tag, ".region"}, 8'(hover_region), 8'(h_reg));
    check_val({tag, ".cor"}, hover_cor, h_cor);
    $display("hover %s (%0d,%0d): region=%0d cor=%h", tag, x, y,
             hover_region, hover_cor);
  endtask

  // Full click with evt_ready=1: left held 3 cycles, then released.
  // Release sampled at edge k; event visible after k+1; handshake at k+2.
  task automatic do_click(input string tag, input logic [11:0] x,
                          input logic [11:0] y, input logic [1:0] h_reg,
                          input logic [7:0] h_cor, input bit exp_evt,
                          input logic [1:0] e_reg, input logic [7:0] e_cor);
    @(negedge clk);
    x_pos     = x;
    y_pos     = y;
    left      = 1'b0;
    evt_ready = 1'b1;
    tick(2);
    check_val({tag, ".hreg"}, 8'(hover_region), 8'(h_reg));
    check_val({tag, ".hcor"}, hover_cor, h_cor);
    @(negedge clk);
    left = 1'b1;
    tick(3);
    @(negedge clk);
    left = 1'b0;
    tick(1);
    check_val({tag, ".valid_k"}, 8'(evt_valid), 8'h00);
    tick(1);
    check_val({tag, ".valid_k1"}, 8'(evt_valid), 8'(exp_evt));
    if (exp_evt) begin
      check_val({tag, ".evt_region"}, 8'(evt_region), 8'(e_reg));
      check_val({tag, ".evt_cor"}, evt_cor, e_cor);
    end
    tick(1);
    check_val({tag, ".valid_after"}, 8'(evt_valid), 8'h00);
    check_val({tag, ".cor_after"}, evt_cor, 8'hFF);
    $display("click %s (%0d,%0d): expect_event=%0d", tag, x, y, exp_evt);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick(2);
    check_val("rst.hreg", 8'(hover_region), 8'h00);
    check_val("rst.hcor", hover_cor, 8'hFF);
    check_val("rst.valid", 8'(evt_valid), 8'h00);
    check_val("rst.ereg", 8'(evt_region), 8'h00);
    check_val("rst.ecor", evt_cor, 8'hFF);
    $display("reset values checked");
    @(negedge clk);
    rst = 1'b0;
    tick(2);

    // Player board click: (165,353) -> col 3, row 7
    do_click("player", 12'd165, 12'd353, 2'd1, 8'h37, 1'b1, 2'd1, 8'h37);

    // Boundary decode
    hover_chk("enemy_last", 12'd767, 12'd128, 2'd2, 8'h90);
    hover_chk("enemy_past", 12'd768, 12'd128, 2'd0, 8'hFF);
    hover_chk("grid_ybot",  12'd165, 12'd447, 2'd1, 8'h39);
    hover_chk("grid_ypast", 12'd165, 12'd448, 2'd0, 8'hFF);
    hover_chk("player_br",  12'd383, 12'd447, 2'd1, 8'h99);
    hover_chk("btn_tl",     12'd320, 12'd500, 2'd3, 8'hFF);
    hover_chk("btn_br",     12'd479, 12'd547, 2'd3, 8'hFF);
    hover_chk("btn_xpast",  12'd480, 12'd500, 2'd0, 8'hFF);
    hover_chk("btn_ypast",  12'd320, 12'd548, 2'd0, 8'hFF);

    // Clicks at edges
    do_click("enemy", 12'd767, 12'd128, 2'd2, 8'h90, 1'b1, 2'd2, 8'h90);
    do_click("enemy_out", 12'd768, 12'd128, 2'd0, 8'hFF, 1'b0, 2'd0, 8'hFF);
    do_click("button", 12'd320, 12'd500, 2'd3, 8'hFF, 1'b1, 2'd3, 8'hFF);
    do_click("button_out", 12'd480, 12'd500, 2'd0, 8'hFF, 1'b0, 2'd0, 8'hFF);

    // Press while disabled is not accepted
    enable = 1'b0;
    do_click("disabled", 12'd165, 12'd353, 2'd1, 8'h37, 1'b0, 2'd0, 8'hFF);
    enable = 1'b1;

    // Drag cancel: press in 8'h37, move to 8'h47 while held, release
    @(negedge clk);
    x_pos = 12'd165;
    y_pos = 12'd353;
    left  = 1'b0;
    tick(2);
    @(negedge clk);
    left = 1'b1;
    tick(3);
    @(negedge clk);
    x_pos = 12'd197;
    tick(3);
    check_val("drag.hcor", hover_cor, 8'h47);
    @(negedge clk);
    left = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check_val("drag.valid", 8'(evt_valid), 8'h00);
    end
    $display("drag cancel (165,353)->(197,353): no event expected");
    do_click("after_drag", 12'd165, 12'd353, 2'd1, 8'h37, 1'b1, 2'd1, 8'h37);

    // Backpressure: event held while evt_ready=0, second click ignored
    @(negedge clk);
    x_pos     = 12'd165;
    y_pos     = 12'd353;
    left      = 1'b0;
    evt_ready = 1'b0;
    tick(2);
    @(negedge clk);
    left = 1'b1;
    tick(3);
    @(negedge clk);
    left = 1'b0;
    tick(2);
    check_val("bp.valid0", 8'(evt_valid), 8'h01);
    check_val("bp.ereg0", 8'(evt_region), 8'h01);
    check_val("bp.ecor0", evt_cor, 8'h37);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      left = (i < 2);
      tick(1);
      check_val("bp.valid_hold", 8'(evt_valid), 8'h01);
      check_val("bp.ecor_hold", evt_cor, 8'h37);
    end
    @(negedge clk);
    evt_ready = 1'b1;
    tick(1);
    check_val("bp.valid_hs", 8'(evt_valid), 8'h00);
    check_val("bp.ecor_hs", evt_cor, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check_val("bp.no_queue", 8'(evt_valid), 8'h00);
    end
    $display("backpressure (165,353): one handshake expected");

    // Reset mid-operation with a pending event and left held through reset
    @(negedge clk);
    evt_ready = 1'b0;
    left      = 1'b0;
    tick(2);
    @(negedge clk);
    left = 1'b1;
    tick(3);
    @(negedge clk);
    left = 1'b0;
    tick(2);
    check_val("rst2.pending", 8'(evt_valid), 8'h01);
    @(negedge clk);
    left = 1'b1;
    rst  = 1'b1;
    tick(1);
    check_val("rst2.valid", 8'(evt_valid), 8'h00);
    check_val("rst2.ecor", evt_cor, 8'hFF);
    check_val("rst2.ereg", 8'(evt_region), 8'h00);
    check_val("rst2.hreg", 8'(hover_region), 8'h00);
    check_val("rst2.hcor", hover_cor, 8'hFF);
    tick(1);
    @(negedge clk);
    rst       = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_val("rst2.held", 8'(evt_valid), 8'h00);
    end
    @(negedge clk);
    left = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_val("rst2.released", 8'(evt_valid), 8'h00);
    end
    $display("reset with left held: no event expected");
    do_click("after_rst", 12'd165, 12'd353, 2'd1, 8'h37, 1'b1, 2'd1, 8'h37);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
